// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
// master = uart_rx (drives byte + valid), slave = consumer (drives ready).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  uart_rx_if.master  rx,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       overrun_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd5
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             sync1_q, s_in_q, s_prev_q;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             ovr_set;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
  logic             par_bad_q, par_bad_d;
`endif

  // State register plus all datapath flops; synchronizer resets to line-idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      sync1_q   <= 1'b1;
      s_in_q    <= 1'b1;
      s_prev_q  <= 1'b1;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sync1_q   <= uart_in;
      s_in_q    <= sync1_q;
      s_prev_q  <= s_in_q;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state and frame datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_prev_q && !s_in_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = s_in_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {s_in_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          perr_d    = (^shift_q) ^ s_in_q;
          par_bad_d = (^shift_q) ^ s_in_q;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (s_in_q) begin
`ifdef UART_RX_PARITY_EN
            done_d = !par_bad_q;
`else
            done_d = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (s_in_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a completed byte may replace one consumed in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (valid_q && rx.rx_ready) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || rx.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (ovr_set)          overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;
  end

  // Outputs
  always_comb begin
    busy        = (state_q != IDLE);
    frame_err   = ferr_q;
    overrun     = overrun_q;
    rx.rx_data  = data_q;
    rx.rx_valid = valid_q;
`ifdef UART_RX_PARITY_EN
    parity_err  = perr_q;
`endif
  end

endmodule
